// File: rtl/vmu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the vector load and store engines.
// Latency: request seen in IDLE -> strobe next cycle -> grant on ack; one transaction in flight.
// Backpressure: engines hold req_en until their grant; requests are only sampled in IDLE.
module vmu_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_req_en_i,
    input  logic [ADDR_WIDTH-1:0] ld_req_addr_i,
    output logic                  ld_grant_o,
    output logic [DATA_WIDTH-1:0] ld_rdata_o,
    output logic                  ld_rvalid_o,
    input  logic                  st_req_en_i,
    input  logic [ADDR_WIDTH-1:0] st_req_addr_i,
    input  logic [DATA_WIDTH-1:0] st_req_data_i,
    output logic                  st_grant_o,
    output logic                  mem_stb_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic                  mem_err_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic OWN_LD = 1'b0;
    localparam logic OWN_ST = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_last_owner;
    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ld_rvalid;
    logic [DATA_WIDTH-1:0] r_ld_rdata;

    logic w_any_req;
    logic w_pick_st;
    logic w_in_wait;
    logic w_tmo;
    logic w_done;
    logic w_fail;

    // Store wins only when it is alone or the load engine was served last.
    assign w_any_req = ld_req_en_i | st_req_en_i;
    assign w_pick_st = st_req_en_i & (~ld_req_en_i | (r_last_owner == OWN_LD));

    assign w_in_wait = (r_state == S_WAIT);
    assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_done    = w_in_wait & (mem_ack_i | mem_err_i | w_tmo);
    // Error beats a simultaneous ack; a timeout only counts when nothing arrived.
    assign w_fail    = w_in_wait & (mem_err_i | (w_tmo & ~mem_ack_i));

    assign ld_grant_o  = w_done & (r_owner == OWN_LD);
    assign st_grant_o  = w_done & (r_owner == OWN_ST);
    assign err_o       = w_fail;
    assign busy_o      = (r_state != S_IDLE);
    assign mem_stb_o   = r_stb;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign ld_rvalid_o = r_ld_rvalid;
    assign ld_rdata_o  = r_ld_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_LD;
            r_last_owner <= OWN_ST;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_ld_rvalid  <= 1'b0;
            r_ld_rdata   <= '0;
        end else begin
            r_stb       <= 1'b0;
            r_ld_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_pick_st;
                        r_last_owner <= w_pick_st;
                        r_we         <= w_pick_st;
                        r_addr       <= w_pick_st ? st_req_addr_i : ld_req_addr_i;
                        r_wdata      <= w_pick_st ? st_req_data_i : '0;
                        r_stb        <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done) begin
                        if (r_owner == OWN_LD) begin
                            r_ld_rvalid <= 1'b1;
                            r_ld_rdata  <= w_fail ? '0 : mem_rdata_i;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmu_mem_arbiter.sv
// Directed bench for vmu_mem_arbiter: store, load, round-robin, bus error, timeout, reset abort.
module tb_vmu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_req_en_i = 1'b0;
    logic [31:0] ld_req_addr_i = '0;
    logic        ld_grant_o;
    logic [31:0] ld_rdata_o;
    logic        ld_rvalid_o;
    logic        st_req_en_i = 1'b0;
    logic [31:0] st_req_addr_i = '0;
    logic [31:0] st_req_data_i = '0;
    logic        st_grant_o;
    logic        mem_stb_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic        mem_err_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        err_o;
    logic        busy_o;

    int n_chk = 0;
    int n_err = 0;
    int n_stb = 0;
    int n_overlap = 0;

    vmu_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_req_en_i  (ld_req_en_i),
        .ld_req_addr_i(ld_req_addr_i),
        .ld_grant_o   (ld_grant_o),
        .ld_rdata_o   (ld_rdata_o),
        .ld_rvalid_o  (ld_rvalid_o),
        .st_req_en_i  (st_req_en_i),
        .st_req_addr_i(st_req_addr_i),
        .st_req_data_i(st_req_data_i),
        .st_grant_o   (st_grant_o),
        .mem_stb_o    (mem_stb_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_err_i    (mem_err_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_stb_o) n_stb++;
    always @(negedge clk) if (ld_grant_o && st_grant_o) n_overlap++;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    int stb0;

    initial begin
        // Reset state
        #3;
        chk("rst_stb",    {63'd0, mem_stb_o},   64'd0);
        chk("rst_busy",   {63'd0, busy_o},      64'd0);
        chk("rst_grants", {62'd0, ld_grant_o, st_grant_o}, 64'd0);
        chk("rst_rvalid", {63'd0, ld_rvalid_o}, 64'd0);
        chk("rst_addr",   {32'd0, mem_addr_o},  64'd0);
        do_reset();

        // 1. Store only, ack two cycles after strobe
        st_req_en_i = 1'b1; st_req_addr_i = 32'h1000; st_req_data_i = 32'hDEADBEEF;
        tick();
        chk("t1_stb",   {63'd0, mem_stb_o},  64'd1);
        chk("t1_we",    {63'd0, mem_we_o},   64'd1);
        chk("t1_addr",  {32'd0, mem_addr_o}, 64'h1000);
        chk("t1_wdata", {32'd0, mem_wdata_o}, 64'hDEADBEEF);
        tick();
        chk("t1_stb_off", {63'd0, mem_stb_o},  64'd0);
        chk("t1_nogrant", {62'd0, ld_grant_o, st_grant_o}, 64'd0);
        tick();
        mem_ack_i = 1'b1; #1;
        chk("t1_grant", {62'd0, ld_grant_o, st_grant_o}, 64'b01);
        chk("t1_err",   {63'd0, err_o}, 64'd0);
        tick();
        mem_ack_i = 1'b0; st_req_en_i = 1'b0; #1;
        chk("t1_idle",   {63'd0, busy_o},      64'd0);
        chk("t1_rvalid", {63'd0, ld_rvalid_o}, 64'd0);

        // 2. Load only
        ld_req_en_i = 1'b1; ld_req_addr_i = 32'h2000;
        tick();
        chk("t2_stb",  {63'd0, mem_stb_o},  64'd1);
        chk("t2_we",   {63'd0, mem_we_o},   64'd0);
        chk("t2_addr", {32'd0, mem_addr_o}, 64'h2000);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678; #1;
        chk("t2_grant", {62'd0, ld_grant_o, st_grant_o}, 64'b10);
        tick();
        mem_ack_i = 1'b0; ld_req_en_i = 1'b0; mem_rdata_i = 32'h0; #1;
        chk("t2_rvalid", {63'd0, ld_rvalid_o}, 64'd1);
        chk("t2_rdata",  {32'd0, ld_rdata_o},  64'h12345678);
        tick();
        chk("t2_rvalid_off", {63'd0, ld_rvalid_o}, 64'd0);

        // 3. Both requesting after reset: L,S,L,S at one transfer per 3 cycles
        do_reset();
        stb0 = n_stb;
        ld_req_en_i = 1'b1; ld_req_addr_i = 32'h4000;
        st_req_en_i = 1'b1; st_req_addr_i = 32'h5000; st_req_data_i = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t3_stb%0d", k), {63'd0, mem_stb_o}, 64'd1);
            chk($sformatf("t3_we%0d", k),  {63'd0, mem_we_o},  64'(k % 2));
            chk($sformatf("t3_addr%0d", k), {32'd0, mem_addr_o}, (k % 2) ? 64'h5000 : 64'h4000);
            tick();
            mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5; #1;
            chk($sformatf("t3_grant%0d", k), {62'd0, ld_grant_o, st_grant_o},
                (k % 2) ? 64'b01 : 64'b10);
            tick();
            mem_ack_i = 1'b0;
        end
        ld_req_en_i = 1'b0; st_req_en_i = 1'b0;
        tick();
        chk("t3_stb_count", 64'(n_stb - stb0), 64'd4);
        chk("t3_rdata", {32'd0, ld_rdata_o}, 64'hA5A5A5A5);

        // 4. Store terminated by bus error
        st_req_en_i = 1'b1; st_req_addr_i = 32'h6000; st_req_data_i = 32'h11;
        tick();
        tick();
        mem_err_i = 1'b1; #1;
        chk("t4_grant", {62'd0, ld_grant_o, st_grant_o}, 64'b01);
        chk("t4_err",   {63'd0, err_o}, 64'd1);
        tick();
        mem_err_i = 1'b0; st_req_en_i = 1'b0; #1;
        chk("t4_idle",    {63'd0, busy_o}, 64'd0);
        chk("t4_err_off", {63'd0, err_o},  64'd0);

        // 5. Load timeout after 4 WAIT cycles, then a late ack
        ld_req_en_i = 1'b1; ld_req_addr_i = 32'h7000;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_wait%0d", i), {61'd0, ld_grant_o, st_grant_o, err_o}, 64'd0);
        end
        tick();
        chk("t5_grant", {62'd0, ld_grant_o, st_grant_o}, 64'b10);
        chk("t5_err",   {63'd0, err_o}, 64'd1);
        tick();
        ld_req_en_i = 1'b0; #1;
        chk("t5_rvalid", {63'd0, ld_rvalid_o}, 64'd1);
        chk("t5_rdata",  {32'd0, ld_rdata_o},  64'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0; #1;
        chk("t5_late_grant", {62'd0, ld_grant_o, st_grant_o}, 64'd0);
        tick();
        mem_ack_i = 1'b0;
        chk("t5_late_busy",   {63'd0, busy_o},      64'd0);
        chk("t5_late_rvalid", {63'd0, ld_rvalid_o}, 64'd0);

        // 6. Reset asserted during WAIT
        st_req_en_i = 1'b1; st_req_addr_i = 32'h8000; st_req_data_i = 32'h22;
        tick();
        tick();
        mem_ack_i = 1'b1;
        rst_n = 1'b0; #1;
        chk("t6_busy",  {63'd0, busy_o},   64'd0);
        chk("t6_grant", {62'd0, ld_grant_o, st_grant_o}, 64'd0);
        chk("t6_addr",  {32'd0, mem_addr_o}, 64'd0);
        chk("t6_we",    {63'd0, mem_we_o},   64'd0);
        mem_ack_i = 1'b0; st_req_en_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        ld_req_en_i = 1'b1; ld_req_addr_i = 32'h3000;
        tick();
        chk("t6_re_stb",  {63'd0, mem_stb_o},  64'd1);
        chk("t6_re_addr", {32'd0, mem_addr_o}, 64'h3000);
        chk("t6_re_we",   {63'd0, mem_we_o},   64'd0);
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D; #1;
        chk("t6_re_grant", {62'd0, ld_grant_o, st_grant_o}, 64'b10);
        tick();
        mem_ack_i = 1'b0; ld_req_en_i = 1'b0; #1;
        chk("t6_re_rdata", {32'd0, ld_rdata_o}, 64'h0BADF00D);
        tick();

        chk("grant_overlap", 64'(n_overlap), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
